// File: rtl/dma_cfg_pkg.sv
// Shared constants, descriptor type and helpers for the DMA configuration block.
package dma_cfg_pkg;

  localparam logic [5:0] REG_SRC     = 6'h00;
  localparam logic [5:0] REG_DST     = 6'h01;
  localparam logic [5:0] REG_LEN     = 6'h02;
  localparam logic [5:0] REG_CTRL    = 6'h03;
  localparam logic [5:0] REG_STATUS  = 6'h04;
  localparam logic [5:0] REG_DONECNT = 6'h05;

  localparam int CTRL_IE_BIT    = 8;
  localparam int CTRL_FLUSH_BIT = 30;
  localparam int CTRL_PUSH_BIT  = 31;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_CNT_LSB   = 4;
  localparam int ST_DONE_BIT  = 8;
  localparam int ST_ERR_BIT   = 9;

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_LAUNCH = 4'b0010;
  localparam logic [3:0] S_BUSY   = 4'b0100;
  localparam logic [3:0] S_GAP    = 4'b1000;

  localparam int DESC_W = 98;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [1:0]  size;
  } desc_t;

  // A descriptor is launchable only with a non-zero length and a defined element size.
  function automatic logic desc_ok(input logic [31:0] len, input logic [1:0] size);
    return (len != 32'h0) && (size != 2'd3);
  endfunction

endpackage

// File: rtl/dma_cfg_ahb_if.sv
// AHB-Lite slave-side bus bundle for the DMA configuration block.
interface dma_cfg_ahb_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/dma_desc_fifo.sv
// Descriptor queue: synchronous FIFO with flush; head entry presented combinationally.
module dma_desc_fifo
  import dma_cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  desc_t                        wdata,
  output desc_t                        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  desc_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_idx;
  logic          do_push, do_pop;

  // Flush restarts the queue at slot 0 so a same-write push lands behind it.
  always_comb begin
    full    = (count == CNT_FULL);
    empty   = (count == {CW{1'b0}});
    do_push = push & (flush | ~full);
    do_pop  = pop & ~empty & ~flush;
    rdata   = mem[rd_ptr];
    if (flush) begin
      wr_idx = {AW{1'b0}};
    end else begin
      wr_idx = wr_ptr;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= do_push ? AW'(1'b1) : {AW{1'b0}};
      count  <= do_push ? CW'(1'b1) : {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_cfg_ahb.sv
// AHB-Lite register block that queues DMA descriptors and launches them one at a time
// on the single-channel engine, tracking completion/error status and interrupt.
module dma_cfg_ahb
  import dma_cfg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  dma_cfg_ahb_if.slave ahb,
  output logic         DMAstart,
  input  logic         DMAdone,
  output logic [31:0]  DMAsrc,
  output logic [31:0]  DMAdst,
  output logic [1:0]   DMAsize,
  output logic [31:0]  DMAlen,
  output logic         IRQ
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             addr_sel, dph_valid, dph_write;
  logic [5:0]       dph_addr;
  logic [31:0]      reg_src, reg_dst, reg_len, hrdata, rd_data, status_word;
  logic [1:0]       ctrl_size;
  logic             ctrl_ie, sts_done, sts_err, done_smp;
  logic [CNT_W-1:0] done_cnt;
  logic [3:0]       state, state_nxt;
  logic             wr_en, push_req, flush_req, push_ok, push_err, sts_w1c, pop, hw_done;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  desc_t            new_desc, head_desc;
  logic             unused_ok;

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign ahb.HRDATA    = hrdata;
  assign IRQ           = ctrl_ie & (sts_done | sts_err);
  assign unused_ok     = ^{ahb.HSIZE, ahb.HADDR[31:8], ahb.HADDR[1:0], ahb.HTRANS[0]};

  dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push_ok),
    .pop   (pop),
    .flush (flush_req),
    .wdata (new_desc),
    .rdata (head_desc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus decode, push qualification and read mux; full is judged before any same-cycle pop.
  always_comb begin
    addr_sel  = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    wr_en     = dph_valid & dph_write;
    push_req  = wr_en & (dph_addr == REG_CTRL) & ahb.HWDATA[CTRL_PUSH_BIT];
    flush_req = wr_en & (dph_addr == REG_CTRL) & ahb.HWDATA[CTRL_FLUSH_BIT];
    sts_w1c   = wr_en & (dph_addr == REG_STATUS);
    push_ok   = push_req & desc_ok(reg_len, ahb.HWDATA[1:0]) & (~fifo_full | flush_req);
    push_err  = push_req & ~push_ok;
    new_desc.src  = reg_src;
    new_desc.dst  = reg_dst;
    new_desc.len  = reg_len;
    new_desc.size = ahb.HWDATA[1:0];
    pop       = (state == S_IDLE) & ~fifo_empty;
    hw_done   = (state == S_BUSY) & done_smp;

    status_word                       = 32'h0;
    status_word[ST_BUSY_BIT]          = (state != S_IDLE);
    status_word[ST_FULL_BIT]          = fifo_full;
    status_word[ST_EMPTY_BIT]         = fifo_empty;
    status_word[ST_CNT_LSB +: 4]      = 4'(fifo_count);
    status_word[ST_DONE_BIT]          = sts_done;
    status_word[ST_ERR_BIT]           = sts_err;

    case (ahb.HADDR[7:2])
      REG_SRC:     rd_data = reg_src;
      REG_DST:     rd_data = reg_dst;
      REG_LEN:     rd_data = reg_len;
      REG_CTRL:    rd_data = {23'h0, ctrl_ie, 6'h0, ctrl_size};
      REG_STATUS:  rd_data = status_word;
      REG_DONECNT: rd_data = 32'(done_cnt);
      default:     rd_data = 32'h0;
    endcase
  end

  // Launch sequencer next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_LAUNCH;
        else             state_nxt = S_IDLE;
      end
      S_LAUNCH: state_nxt = S_BUSY;
      S_BUSY: begin
        if (done_smp) state_nxt = S_GAP;
        else          state_nxt = S_BUSY;
      end
      S_GAP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Address-phase capture and registered read data
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_addr  <= 6'h0;
      hrdata    <= 32'h0;
    end else begin
      dph_valid <= addr_sel;
      dph_write <= ahb.HWRITE;
      dph_addr  <= ahb.HADDR[7:2];
      hrdata    <= (addr_sel && !ahb.HWRITE) ? rd_data : 32'h0;
    end
  end

  // Programming registers and sticky status; hardware set beats software clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      reg_src   <= 32'h0;
      reg_dst   <= 32'h0;
      reg_len   <= 32'h0;
      ctrl_size <= 2'd0;
      ctrl_ie   <= 1'b0;
      sts_done  <= 1'b0;
      sts_err   <= 1'b0;
      done_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en) begin
        case (dph_addr)
          REG_SRC: reg_src <= ahb.HWDATA;
          REG_DST: reg_dst <= ahb.HWDATA;
          REG_LEN: reg_len <= ahb.HWDATA;
          REG_CTRL: begin
            ctrl_size <= ahb.HWDATA[1:0];
            ctrl_ie   <= ahb.HWDATA[CTRL_IE_BIT];
          end
          default: begin
          end
        endcase
      end
      if (hw_done)                                sts_done <= 1'b1;
      else if (sts_w1c && ahb.HWDATA[ST_DONE_BIT]) sts_done <= 1'b0;
      if (push_err)                               sts_err <= 1'b1;
      else if (sts_w1c && ahb.HWDATA[ST_ERR_BIT])  sts_err <= 1'b0;
      if (hw_done) done_cnt <= done_cnt + 1'b1;
    end
  end

  // Sequencer state, engine-side outputs and sampled completion
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      done_smp <= 1'b0;
      DMAstart <= 1'b0;
      DMAsrc   <= 32'h0;
      DMAdst   <= 32'h0;
      DMAlen   <= 32'h0;
      DMAsize  <= 2'd0;
    end else begin
      state    <= state_nxt;
      done_smp <= DMAdone;
      DMAstart <= pop;
      if (pop) begin
        DMAsrc  <= head_desc.src;
        DMAdst  <= head_desc.dst;
        DMAlen  <= head_desc.len;
        DMAsize <= head_desc.size;
      end
    end
  end

endmodule

// File: tb/tb_dma_cfg_ahb.sv
// Randomized self-checking bench for dma_cfg_ahb against a descriptor-queue reference model.
module tb_dma_cfg_ahb;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [1:0]  size;
  } mdesc_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        DMAdone = 1'b0;
  logic        DMAstart, IRQ;
  logic [31:0] DMAsrc, DMAdst, DMAlen;
  logic [1:0]  DMAsize;

  dma_cfg_ahb_if bus();

  dma_cfg_ahb #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus), .DMAstart(DMAstart), .DMAdone(DMAdone),
    .DMAsrc(DMAsrc), .DMAdst(DMAdst), .DMAsize(DMAsize), .DMAlen(DMAlen), .IRQ(IRQ)
  );

  int total = 0, bad = 0, cyc = 0, launches = 0, wr_cyc = 0, last_start_cyc = -1;
  int done_delay = -1, countdown = -1, last_done_cyc = -1, m_donecnt = 0;
  logic prev_start = 1'b0;
  logic [31:0] sh_src, sh_dst, sh_len, rd;
  logic m_ie, m_done, m_err, m_busy;
  mdesc_t exp_q[$];
  mdesc_t mon_e;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  initial forever #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] m_status();
    return {22'h0, m_err, m_done, 4'(exp_q.size()), 1'b0,
            exp_q.size() == 0, exp_q.size() == DEPTH, m_busy};
  endfunction

  function automatic logic [31:0] m_irq();
    return {31'h0, m_ie & (m_done | m_err)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    sh_src = 32'h0; sh_dst = 32'h0; sh_len = 32'h0;
    m_ie = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_donecnt = 0; launches = 0; countdown = -1; last_done_cyc = -1; done_delay = -1;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d);
    case (a)
      6'h00: sh_src = d;
      6'h01: sh_dst = d;
      6'h02: sh_len = d;
      6'h03: begin
        m_ie = d[8];
        if (d[30]) exp_q.delete();
        if (d[31]) begin
          if (exp_q.size() >= DEPTH || sh_len == 32'h0 || d[1:0] == 2'd3) m_err = 1'b1;
          else exp_q.push_back('{sh_src, sh_dst, sh_len, d[1:0]});
        end
      end
      6'h04: begin
        if (d[8]) m_done = 1'b0;
        if (d[9]) m_err = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic ahb_write(input logic [7:0] addr, input logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {24'h0, addr};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d; wr_cyc = cyc;
    @(posedge HCLK); #1;
    model_write(addr[7:2], d);
  endtask

  task automatic ahb_read(input logic [7:0] addr, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {24'h0, addr};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic push_desc(input logic [31:0] s, input logic [31:0] t, input logic [31:0] n,
                           input logic [31:0] ctrl);
    ahb_write(8'h00, s);
    ahb_write(8'h04, t);
    ahb_write(8'h08, n);
    ahb_write(8'h0C, ctrl);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge HCLK); #3;
    HRESETn = 1'b0;
    model_reset();
    #1;
    check_val("rst_start", {31'h0, DMAstart}, 32'h0);
    check_val("rst_src", DMAsrc, 32'h0);
    check_val("rst_len", DMAlen, 32'h0);
    check_val("rst_irq", {31'h0, IRQ}, 32'h0);
    check_val("rst_hready", {31'h0, bus.HREADYOUT}, 32'h1);
    check_val("rst_hresp", {31'h0, bus.HRESP}, 32'h0);
    check_val("rst_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
  endtask

  // Engine stand-in: watches launches against the model and answers with DMAdone.
  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        DMAdone = 1'b0; countdown = -1; prev_start = 1'b0;
      end else begin
        if (DMAdone) DMAdone = 1'b0;
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            DMAdone = 1'b1; m_done = 1'b1; m_donecnt++; m_busy = 1'b0;
            last_done_cyc = cyc; countdown = -1;
          end
        end
        if (DMAstart) begin
          check_val("start_width", {31'h0, prev_start}, 32'h0);
          check_val("start_expected", {31'h0, exp_q.size() > 0}, 32'h1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("launch_src", DMAsrc, mon_e.src);
            check_val("launch_dst", DMAdst, mon_e.dst);
            check_val("launch_len", DMAlen, mon_e.len);
            check_val("launch_size", {30'h0, DMAsize}, {30'h0, mon_e.size});
          end
          if (last_done_cyc >= 0) check_val("start_gap", {31'h0, (cyc - last_done_cyc) >= 4}, 32'h1);
          last_done_cyc = -1;
          last_start_cyc = cyc;
          launches++;
          m_busy = 1'b1;
          if (done_delay == 0) countdown = $urandom_range(1, 8);
          else if (done_delay > 0) countdown = done_delay;
        end
        prev_start = DMAstart;
      end
    end
  end

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = 32'h0; bus.HREADY = 1'b1;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Reset state and single transfer with completion, IRQ and W1C
    ahb_read(8'h10, rd);   check_val("rst_status", rd, 32'h4);
    ahb_read(8'h14, rd);   check_val("rst_donecnt", rd, 32'h0);
    done_delay = 20;
    push_desc(32'h2000_0000, 32'h2000_1000, 32'd16, 32'h8000_0102);
    wait_cyc(4);
    check_val("t1_latency", last_start_cyc - wr_cyc, 32'd2);
    check_val("t1_size", {30'h0, DMAsize}, 32'd2);
    check_val("t1_len", DMAlen, 32'd16);
    ahb_read(8'h0C, rd);   check_val("t1_ctrl_rb", rd, 32'h102);
    ahb_read(8'h00, rd);   check_val("t1_src_rb", rd, sh_src);
    wait_cyc(30);
    ahb_read(8'h10, rd);   check_val("t1_status", rd, m_status());
    ahb_read(8'h14, rd);   check_val("t1_donecnt", rd, 32'(m_donecnt));
    check_val("t1_irq", {31'h0, IRQ}, m_irq());
    ahb_write(8'h10, 32'h100);
    check_val("t1_irq_clr", {31'h0, IRQ}, m_irq());
    ahb_read(8'h10, rd);   check_val("t1_status_clr", rd, m_status());

    // Fill the queue behind a stuck transfer, then overflow
    do_reset();
    for (int i = 0; i < 6; i++)
      push_desc($urandom, $urandom, $urandom_range(1, 100), 32'h8000_0000 | $urandom_range(0, 2));
    wait_cyc(5);
    ahb_read(8'h10, rd);   check_val("t2_status", rd, m_status());
    check_val("t2_launches", launches, 32'd1);

    // Reset while busy with entries queued
    do_reset();
    ahb_read(8'h10, rd);   check_val("t6_status", rd, 32'h4);
    wait_cyc(10);
    check_val("t6_launches", launches, 32'd0);

    // Rejected descriptors: zero length and reserved size
    push_desc(32'h1111_0000, 32'h2222_0000, 32'd0, 32'h8000_0001);
    push_desc(32'h1111_0000, 32'h2222_0000, 32'd5, 32'h8000_0003);
    wait_cyc(10);
    ahb_read(8'h10, rd);   check_val("t3_status", rd, m_status());
    check_val("t3_launches", launches, 32'd0);

    // Three descriptors completed in FIFO order
    do_reset();
    done_delay = 3;
    for (int i = 0; i < 3; i++)
      push_desc(32'h1000_0000 + 32'(i) * 32'h100, 32'h3000_0000, 32'd8, 32'h8000_0001);
    wait_cyc(40);
    check_val("t4_launches", launches, 32'd3);
    ahb_read(8'h14, rd);   check_val("t4_donecnt", rd, 32'(m_donecnt));
    ahb_read(8'h10, rd);   check_val("t4_status", rd, m_status());

    // Flush behind an in-flight transfer
    do_reset();
    for (int i = 0; i < 4; i++)
      push_desc(32'h4000_0000 + 32'(i), 32'h5000_0000, 32'd4, 32'h8000_0002);
    wait_cyc(5);
    ahb_write(8'h0C, 32'h4000_0000);
    ahb_read(8'h10, rd);   check_val("t5_status_flush", rd, m_status());
    countdown = 1;
    wait_cyc(20);
    check_val("t5_launches", launches, 32'd1);
    ahb_read(8'h14, rd);   check_val("t5_donecnt", rd, 32'(m_donecnt));
    ahb_read(8'h10, rd);   check_val("t5_status", rd, m_status());

    // Random programming traffic with randomly timed completions
    do_reset();
    done_delay = 0;
    for (int k = 0; k < 80; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5)
        push_desc($urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)),
                  32'h8000_0000 | ({31'h0, 1'($urandom)} << 8) | 32'($urandom_range(0, 3)));
      else if (op <= 8)
        ahb_write(8'(4 * $urandom_range(0, 2)), $urandom);
      else
        wait_cyc($urandom_range(1, 10));
    end
    wait_cyc(150);
    ahb_read(8'h10, rd);   check_val("rnd_status", rd, m_status());
    ahb_read(8'h14, rd);   check_val("rnd_donecnt", rd, 32'(m_donecnt));
    check_val("rnd_irq", {31'h0, IRQ}, m_irq());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_cfg_ahb.md
Name: dma_cfg_ahb

Overview:
- AHB-Lite slave register block that the CPU uses to program the single-channel DMA engine.
- Holds a small descriptor queue and launches queued transfers one at a time by pulsing DMAstart and waiting for DMAdone.
- Latches completion and error status and raises an interrupt.
- Sits on the system AHB matrix (slave side) and directly upstream of the DMA engine's DMAstart/DMAsrc/DMAdst/DMAsize/DMAlen/DMAdone interface.

Parameters:
- DEPTH, 4, descriptor queue entries (power of 2, >=2).
- CNT_W, 16, width of completed-transfer counter.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset; one clock; reset is asynchronous and active-low
- HSEL  in  1  slave select
- HADDR  in  32  address; only [7:2] decoded
- HTRANS  in  2  transfer type; NONSEQ/SEQ valid
- HWRITE  in  1  write
- HSIZE  in  3  size; word accesses only, others treated as word
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HREADYOUT  out  1  always 1
- HRESP  out  1  always 0 (OKAY)
- HRDATA  out  32  read data (data phase)
- DMAstart  out  1  one-cycle launch pulse to engine
- DMAdone  in  1  engine completion, level-sampled
- DMAsrc  out  32  source address of launched descriptor
- DMAdst  out  32  destination address of launched descriptor
- DMAsize  out  2  element size: 0=byte, 1=half, 2=word
- DMAlen  out  32  element count
- IRQ  out  1  interrupt, level

Behaviour:
- Reset values: all outputs 0 except HREADYOUT=1; registers, queue, counters and stickies cleared; FSM to IDLE.
- Address phase is captured when HSEL&HTRANS[1]&HREADY. The write takes effect at the end of the data phase.
- Read data is registered from the address phase and is valid in the data phase (zero wait).
- Register map:
  - 0x00 SRC rw.
  - 0x04 DST rw.
  - 0x08 LEN rw.
  - 0x0C CTRL: [1:0] SIZE rw; [8] IE rw; [31] PUSH write-1 action, reads 0; [30] FLUSH write-1 action, reads 0.
  - 0x10 STATUS: [0] busy (FSM!=IDLE); [1] full; [2] empty; [7:4] count; [8] DONE sticky; [9] ERR sticky. Write-1-to-clear on [9:8].
  - 0x14 DONECNT ro.
  - Unmapped offsets read 0; writes to them are ignored.
- PUSH enqueues {SRC,DST,LEN,SIZE field of the same write}. The push is rejected (entry dropped, ERR set) if any of the following holds:
  - queue full (judged before any same-cycle pop);
  - LEN==0;
  - SIZE==3.
- FLUSH empties the queue (entries not yet launched). An in-flight transfer is unaffected. If PUSH and FLUSH are in the same write, flush occurs first, then push.
- FSM states:
  - IDLE: queue non-empty -> pop head into the DMA* output registers, go to LAUNCH.
  - LAUNCH: DMAstart=1 for exactly this cycle, go to BUSY.
  - BUSY: on DMAdone=1 -> set DONE, increment DONECNT (wraps at 2^CNT_W), go to GAP.
  - GAP: one cycle, DMAdone ignored (engine returning to idle), go to IDLE.
- Timing: a push in data-phase cycle T gives pop at T+1, DMAstart high at T+2. Back-to-back descriptors give minimum 4 cycles from DMAdone to the next DMAstart.
- DMAsrc/dst/size/len stay stable from pop until the next pop. They are not cleared on completion.
- DMAdone seen outside BUSY is ignored.
- Software W1C in the same cycle as a hardware set: set wins.
- Software writes to SRC/DST/LEN/CTRL while busy are allowed; they affect only future pushes.
- IRQ = IE & (DONE | ERR), combinational from registers.
- Reset mid-transfer: everything clears immediately, DMAstart=0. The engine is reset by the same HRESETn.

Decomposition:
- Package dma_cfg_pkg holds:
  - register offset constants;
  - STATUS/CTRL bit positions;
  - FSM state encoding (one-hot, 4 states);
  - descriptor width constant (98 = 32+32+32+2).
- Sub-module dma_desc_fifo: synchronous FIFO, DEPTH x 98 bits.
  - Interface: push, pop, flush, full, empty, count.
  - Read data is the head entry, combinational.

Test Plan:
- Program SRC=0x2000_0000, DST=0x2000_1000, LEN=16, CTRL=0x8000_0102 -> 2 cycles after the write data phase, DMAstart pulses for 1 cycle with DMAsize=2, DMAlen=16. Respond with DMAdone 20 cycles later -> STATUS[8]=1, DONECNT=1, IRQ=1. W1C 0x100 -> IRQ=0.
- Push 5 descriptors while the engine is held busy (DMAdone never asserted) -> first launches. Pushes 2-5 fill the queue (DEPTH=4), STATUS count reads 4, full=1. A 6th push sets ERR and is dropped.
- Push LEN=0, then SIZE=3 -> neither launches, ERR=1, empty=1, DMAstart never asserted.
- Queue 3 descriptors and complete each with a 1-cycle DMAdone -> DMAstart pulses exactly 3 times with matching DMAsrc per descriptor in FIFO order, spaced >=4 cycles after each DMAdone, DONECNT=3.
- Queue 3 with the first in flight, write FLUSH -> count=0. Finish the in-flight transfer -> DONECNT=1, no further DMAstart.
- Assert HRESETn low while in BUSY with 2 queued -> all outputs reset asynchronously. After release: STATUS=0x4, no DMAstart.
